// File: rtl/divider_if.sv
// rtl/divider_if.sv - operation encoding and request/result bundle for the EX-stage divider

package divider_pkg;
    // RV32M funct3 encodings shared by the mul/div unit
    typedef enum logic [2:0] {
        FUNCT3_MUL    = 3'b000,
        FUNCT3_MULH   = 3'b001,
        FUNCT3_MULHSU = 3'b010,
        FUNCT3_MULHU  = 3'b011,
        FUNCT3_DIV    = 3'b100,
        FUNCT3_DIVU   = 3'b101,
        FUNCT3_REM    = 3'b110,
        FUNCT3_REMU   = 3'b111
    } muldiv_funct3_t;
endpackage

interface divider_if;
    import divider_pkg::*;

    logic [31:0]    a;
    logic [31:0]    b;
    logic           start;
    muldiv_funct3_t sign;
    logic [31:0]    quotient;
    logic [31:0]    remainder;
    logic           done;

    modport master (output a, b, start, sign, input quotient, remainder, done);
    modport slave  (input a, b, start, sign, output quotient, remainder, done);
endinterface

// File: rtl/divider.sv
// rtl/divider.sv - iterative 32-bit restoring divider for div/divu/rem/remu

module divider
    import divider_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    divider_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  cnt;
    logic [31:0] r_reg;
    logic [31:0] q_reg;
    logic [31:0] d_reg;
    logic        neg_q;
    logic        neg_r;

    logic        op_signed;
    logic        special;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] rq;
    logic [31:0] trial;
    logic        trial_ge;
    logic [31:0] r_step;
    logic [31:0] q_step;

    // Operand decode and one restoring step. The 33-bit trial {R,Q[31]}-D is
    // only kept when non-negative, and then its top bit is zero, so the low
    // 32 bits of the difference carry the whole result.
    always_comb begin
        op_signed = !(bus.sign == FUNCT3_DIVU || bus.sign == FUNCT3_REMU);
        a_mag     = (op_signed && bus.a[31]) ? -bus.a : bus.a;
        b_mag     = (op_signed && bus.b[31]) ? -bus.b : bus.b;
        special   = (bus.b == 32'h0) ||
                    (op_signed && bus.a == 32'h8000_0000 && bus.b == 32'hFFFF_FFFF);
        rq        = {r_reg, q_reg[31]};
        trial_ge  = rq >= {1'b0, d_reg};
        trial     = rq[31:0] - d_reg;
        r_step    = trial_ge ? trial : rq[31:0];
        q_step    = {q_reg[30:0], trial_ge};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: accept in IDLE, iterate 32 times in CALC, abort on start low
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.start) state_next = special ? DONE : CALC;
            CALC: begin
                if (!bus.start)       state_next = IDLE;
                else if (cnt == 5'd31) state_next = DONE;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture magnitudes on accept, shift/subtract in CALC, load results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= 5'd0;
            r_reg         <= 32'h0;
            q_reg         <= 32'h0;
            d_reg         <= 32'h0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            bus.quotient  <= 32'h0;
            bus.remainder <= 32'h0;
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    if (special) begin
                        if (bus.b == 32'h0) begin
                            bus.quotient  <= 32'hFFFF_FFFF;
                            bus.remainder <= bus.a;
                        end else begin
                            bus.quotient  <= 32'h8000_0000;
                            bus.remainder <= 32'h0;
                        end
                    end else begin
                        r_reg <= 32'h0;
                        q_reg <= a_mag;
                        d_reg <= b_mag;
                        neg_q <= op_signed && (bus.a[31] ^ bus.b[31]);
                        neg_r <= op_signed && bus.a[31];
                        cnt   <= 5'd0;
                    end
                end
                CALC: if (bus.start) begin
                    r_reg <= r_step;
                    q_reg <= q_step;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        bus.quotient  <= neg_q ? -q_step : q_step;
                        bus.remainder <= neg_r ? -r_step : r_step;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result-valid pulse: high for the single cycle spent in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.done <= 1'b0;
        else     bus.done <= (state_next == DONE);
    end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - randomized self-checking bench for divider

module tb_divider;
    import divider_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    divider_if bus ();

    divider dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V M-extension division semantics in plain arithmetic
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    input muldiv_funct3_t f,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output int lat);
        bit     is_unsigned = (f == FUNCT3_DIVU) || (f == FUNCT3_REMU);
        longint sa, sb, lq, lr;
        lat = 33;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a; lat = 1;
        end else if (!is_unsigned && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'h0; lat = 1;
        end else if (is_unsigned) begin
            q = a / b; r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q = lq[31:0]; r = lr[31:0];
        end
    endfunction

    // Present a request and wait for done; returns the cycle count from accept.
    // Operand inputs are scrambled after the accepting edge to show they were captured.
    task automatic wait_done(input string tag, input int exp_lat, output int cyc);
        cyc = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                bus.a    = $urandom;
                bus.b    = $urandom;
                bus.sign = muldiv_funct3_t'(3'($urandom_range(0, 7)));
            end
            if (bus.done) break;
            if (cyc > 40) break;
        end
        check({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input muldiv_funct3_t f, input bit drop_after);
        logic [31:0] eq, er;
        int lat, cyc;
        ref_div(a, b, f, eq, er, lat);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.sign = f; bus.start = 1'b1;
        wait_done(tag, lat, cyc);
        check({tag, ".q"}, bus.quotient, eq);
        check({tag, ".r"}, bus.remainder, er);
        if (drop_after) begin
            @(negedge clk);
            bus.start = 1'b0;
            @(posedge clk); #1;
            check({tag, ".pulse"}, 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ra, rb, eq, er, hold_q, hold_r;
        muldiv_funct3_t rf;
        int lat, cyc, seen;

        bus.a = '0; bus.b = '0; bus.start = 1'b0; bus.sign = FUNCT3_DIV;
        repeat (2) @(posedge clk);
        #1;
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.q", bus.quotient, 32'h0);
        check("reset.r", bus.remainder, 32'h0);
        @(negedge clk); rst = 1'b0;

        run_op("divu_100_7", 32'd100, 32'd7, FUNCT3_DIVU, 1);
        run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, FUNCT3_DIV, 1);
        run_op("rem_7_m2", 32'd7, 32'hFFFF_FFFE, FUNCT3_REM, 1);
        run_op("div_bzero", 32'h1234_5678, 32'h0, FUNCT3_DIV, 1);
        run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, FUNCT3_DIV, 1);
        run_op("divu_ovfops", 32'h8000_0000, 32'hFFFF_FFFF, FUNCT3_DIVU, 1);
        run_op("remu_bzero", 32'hDEAD_BEEF, 32'h0, FUNCT3_REMU, 1);
        run_op("div_minint_2", 32'h8000_0000, 32'd2, FUNCT3_DIV, 1);
        run_op("other_enc", 32'hFFFF_FFF9, 32'd2, FUNCT3_MULHU, 1);

        // Abort: drop start 10 cycles into CALC
        hold_q = bus.quotient; hold_r = bus.remainder;
        @(negedge clk);
        bus.a = 32'd1000; bus.b = 32'd3; bus.sign = FUNCT3_DIVU; bus.start = 1'b1;
        repeat (11) @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) seen++;
        end
        check("abort.nodone", 32'(seen), 32'd0);
        check("abort.q_held", bus.quotient, hold_q);
        check("abort.r_held", bus.remainder, hold_r);
        run_op("after_abort", 32'd9, 32'd3, FUNCT3_DIVU, 1);

        // Reset 20 cycles into CALC, asserted between clock edges
        @(negedge clk);
        bus.a = 32'd77; bus.b = 32'd5; bus.sign = FUNCT3_DIV; bus.start = 1'b1;
        repeat (21) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_mid.done", 32'(bus.done), 32'd0);
        check("rst_mid.q", bus.quotient, 32'h0);
        check("rst_mid.r", bus.remainder, 32'h0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done) seen++;
        end
        check("rst_mid.nodone", 32'(seen), 32'd0);
        run_op("after_rst", 32'd77, 32'd5, FUNCT3_DIV, 1);

        // Back-to-back: start held through done, next operands presented in DONE
        run_op("b2b_first", 32'd50, 32'd6, FUNCT3_DIVU, 0);
        @(negedge clk);
        bus.a = 32'hFFFF_FFFF; bus.b = 32'h10; bus.sign = FUNCT3_DIVU;
        cyc = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done || cyc > 40) break;
        end
        check("b2b.spacing", 32'(cyc), 32'd34);
        check("b2b.q", bus.quotient, 32'h0FFF_FFFF);
        check("b2b.r", bus.remainder, 32'hF);
        @(negedge clk); bus.start = 1'b0;

        // Randomized requests, biased toward the boundary operands
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            rf = muldiv_funct3_t'(3'($urandom_range(0, 7)));
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                4: ra = 32'h8000_0000;
                default: ;
            endcase
            ref_div(ra, rb, rf, eq, er, lat);
            run_op($sformatf("rand%0d", i), ra, rb, rf, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/divider.md
# divider

Iterative 32-bit restoring divider implementing the RV32M `div`, `divu`, `rem` and `remu` operations. It is the companion of the multiplier in the EX-stage mul/div unit and uses the same `start`/`done` request protocol. The pipeline holds `start` high, and stalls, until `done` pulses. The divider retires one quotient bit per cycle. RISC-V divide-by-zero and signed-overflow results are produced with a short-cut latency.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `a` input 32: dividend.
- `b` input 32: divisor.
- `start` input 1: level request; the pipeline holds it high from issue until `done`.
- `sign` input `muldiv_funct3_t`: operation select. `div` and `rem` are signed; `divu` and `remu` are unsigned. Any other encoding is treated as signed.
- `quotient` output 32: registered quotient, stable from `done` until the next accepted request.
- `remainder` output 32: registered remainder, same timing as `quotient`.
- `done` output 1: registered one-cycle result-valid pulse.

## Operation
- **States:** IDLE, CALC and DONE.
- **IDLE:**
  - If `start`=1, capture `a`, `b` and the signedness of `sign`.
  - Signed operands are converted to magnitudes, and the negate-quotient (`a[31]^b[31]`) and negate-remainder (`a[31]`) flags are stored.
  - Go to CALC with iteration counter = 0.
  - If the request is a special case, go directly to DONE with the special result loaded instead.
- **Special cases**, decided on the raw captured operands:
  - `b`=0, any signedness: quotient = 0xFFFFFFFF, remainder = `a`.
  - Signed with `a`=0x80000000 and `b`=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- **CALC iteration:**
  - Compute the 33-bit trial {R[31:0], Q[31]} − D.
  - If the trial is non-negative: R ← trial, and shift Q left with a 1.
  - Otherwise: R ← {R[30:0], Q[31]}, and shift Q left with a 0.
  - Increment the counter.
  - After the 32nd iteration, apply the sign fix-ups (two's complement of Q and/or R per the stored flags), load `quotient`/`remainder`, and go to DONE.
- **Abort:** `start`=0 in CALC sends the FSM back to IDLE. `done` does not pulse, and `quotient`/`remainder` keep their previous values.
- **DONE:**
  - `done`=1 for exactly this cycle; go to IDLE unconditionally.
  - `start` is ignored in DONE.
  - If `start` is still high in the following IDLE cycle, a new request is accepted with the operands present then. The pipeline either drops `start` or presents the next instruction's operands.
- **Width rules:**
  - The remainder register is 32 bits and the trial subtract is 33 bits; no other widening.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned.

## Timing
- **Reset values** (on `rst` assertion, asynchronously): state = IDLE, `done`=0, `quotient`=0, `remainder`=0, counter = 0.
- **Reset mid-operation** (any state): immediate return to IDLE, no `done` pulse, outputs zeroed.
- **Normal latency:**
  - The accepting edge is E0, the edge that samples `start`=1 in IDLE.
  - Iterations occur on edges E1..E32; results load on E32.
  - `done` is high in the cycle after E32, i.e. 33 cycles after E0.
- **Special-case latency:** results load on E0; `done` is high in the cycle after E0.
- **Request spacing:** back-to-back requests have a minimum spacing of 34 cycles normal (1 IDLE + 32 CALC + 1 DONE) and 2 cycles special-case.
- **Stability:** `quotient`/`remainder` change only on the loading edge or on reset. They are valid whenever `done`=1 and held afterwards.
- **Operand changes during CALC:** changes on `a`, `b` or `sign` have no effect, since operands were captured at E0.

## Test plan
- **`divu` normal:** a=100, b=7, `start` held → `done` 33 cycles after accept; quotient = 14, remainder = 2.
- **`div` signs:** a=−7 (0xFFFFFFF9), b=2 → quotient = 0xFFFFFFFD (−3), remainder = 0xFFFFFFFF (−1). With `rem` and a=7, b=−2 → quotient = 0xFFFFFFFD, remainder = 1.
- **Special cases:**
  - `div` with b=0, a=0x12345678 → `done` one cycle after accept; quotient = 0xFFFFFFFF, remainder = 0x12345678.
  - `div` with a=0x80000000, b=0xFFFFFFFF → quotient = 0x80000000, remainder = 0, 1-cycle latency.
  - `divu` with the same operands → quotient = 0, remainder = 0x80000000, full latency.
- **Abort:** drop `start` 10 cycles into CALC → no `done` pulse, outputs unchanged. Re-raise `start` with a=9, b=3 → `done` 33 cycles later, quotient = 3, remainder = 0.
- **Reset mid-operation:** assert `rst` 20 cycles into CALC, asynchronously off a clock edge → `done`=0 and outputs = 0 immediately. After release, a new request completes normally.
- **Back-to-back requests:** keep `start` high through `done` with new operands a=0xFFFFFFFF, b=0x10 (`divu`) → second `done` 34 cycles after the first; quotient = 0x0FFFFFFF, remainder = 0xF.
